// File: rtl/star_collect_ctrl.sv
// star_collect_ctrl: counts collected stars from sticky touch flags, accumulates
// a saturating score and runs the star-power timer with its end-of-power blink.
// Optional build macro STAR_COMBO_EN: combo multiplier on points while powered.
module star_collect_ctrl #(
  parameter int unsigned NUM_STARS    = 3,
  parameter int unsigned STAR_POINTS  = 100,
  parameter int unsigned SCORE_MAX    = 9999,
  parameter int unsigned POWER_FRAMES = 600,
  parameter int unsigned WARN_FRAMES  = 120,
  parameter int unsigned BLINK_DIV    = 8
) (
  input  logic                 sys_clk,
  input  logic                 RST_N,
  input  logic [NUM_STARS-1:0] touch_star,
  input  logic                 frame_tick,
  output logic [3:0]           stars_collected,
  output logic [13:0]          score,
  output logic                 powered,
  output logic                 blink,
  output logic                 all_collected,
  output logic [9:0]           power_left
);

  localparam int unsigned BW = $clog2(BLINK_DIV + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POWER = 2'd1,
    ST_WARN  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_STARS-1:0]   touch_d_q, touch_d_d;
  logic [3:0]             stars_q, stars_d;
  logic [13:0]            score_q, score_d;
  logic [9:0]             power_left_q, power_left_d;
  logic                   blink_q, blink_d;
  logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
  logic                   all_coll_q, all_coll_d;
  logic                   powered_q, powered_d;

  logic [NUM_STARS-1:0]   new_mask_s;
  logic [3:0]             new_cnt_s;
  logic [14:0]            points_s;
  logic [14:0]            add_s;
  logic [14:0]            score_sum_s;
  logic [4:0]             star_sum_s;
  logic [9:0]             pl_dec_s;
  logic [BW-1:0]          cnt_inc_s;

`ifdef STAR_COMBO_EN
  logic [1:0]             combo_q, combo_d;
`endif

  // Rising-edge detect on the sticky touch flags and count of new pickups this cycle.
  always_comb begin
    touch_d_d  = touch_star;
    new_mask_s = touch_star & ~touch_d_q;
    new_cnt_s  = 4'd0;
    for (int i = 0; i < int'(NUM_STARS); i++) begin
      new_cnt_s = new_cnt_s + {3'd0, new_mask_s[i]};
    end
  end

  // Power FSM: reload on any pickup, count down on frame ticks, blink during warning.
  always_comb begin
    state_d      = state_q;
    power_left_d = power_left_q;
    blink_d      = blink_q;
    blink_cnt_d  = blink_cnt_q;
    pl_dec_s     = power_left_q - 10'd1;
    cnt_inc_s    = blink_cnt_q + {{(BW-1){1'b0}}, 1'b1};
    if (new_cnt_s != 4'd0) begin
      // a reload takes priority over a frame tick in the same cycle
      state_d      = ST_POWER;
      power_left_d = 10'(POWER_FRAMES);
      blink_d      = 1'b0;
      blink_cnt_d  = {BW{1'b0}};
    end else if (frame_tick) begin
      case (state_q)
        ST_POWER: begin
          power_left_d = pl_dec_s;
          if (pl_dec_s <= 10'(WARN_FRAMES)) begin
            state_d     = ST_WARN;
            blink_cnt_d = {BW{1'b0}};
            blink_d     = 1'b1;
          end else begin
            state_d     = ST_POWER;
          end
        end
        ST_WARN: begin
          if (power_left_q <= 10'd1) begin
            state_d      = ST_IDLE;
            power_left_d = 10'd0;
            blink_d      = 1'b0;
            blink_cnt_d  = {BW{1'b0}};
          end else if (cnt_inc_s == BW'(BLINK_DIV)) begin
            power_left_d = pl_dec_s;
            blink_cnt_d  = {BW{1'b0}};
            blink_d      = ~blink_q;
          end else begin
            power_left_d = pl_dec_s;
            blink_cnt_d  = cnt_inc_s;
          end
        end
        default: begin
          // idle ignores frame ticks and keeps the timer at zero
          state_d      = ST_IDLE;
          power_left_d = 10'd0;
          blink_d      = 1'b0;
          blink_cnt_d  = {BW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
    powered_d = (state_d != ST_IDLE);
  end

`ifdef STAR_COMBO_EN
  // Combo level: grows while powered, restarts when collected from idle or when power ends.
  always_comb begin
    combo_d = combo_q;
    if (new_cnt_s != 4'd0) begin
      if (state_q != ST_IDLE) begin
        combo_d = (combo_q == 2'd3) ? 2'd3 : combo_q + 2'd1;
      end else begin
        combo_d = 2'd0;
      end
    end else if (state_d == ST_IDLE) begin
      combo_d = 2'd0;
    end else begin
      combo_d = combo_q;
    end
    points_s = 15'(STAR_POINTS) << combo_d;
  end
`else
  // Fixed points per star when the combo multiplier is not built in.
  always_comb begin
    points_s = 15'(STAR_POINTS);
  end
`endif

  // Star count, saturating score and the one-shot all-collected pulse.
  always_comb begin
    add_s       = 15'(new_cnt_s) * points_s;
    score_sum_s = {1'b0, score_q} + add_s;
    if (score_sum_s > 15'(SCORE_MAX)) begin
      score_d = 14'(SCORE_MAX);
    end else begin
      score_d = score_sum_s[13:0];
    end
    star_sum_s = {1'b0, stars_q} + {1'b0, new_cnt_s};
    if (star_sum_s > 5'(NUM_STARS)) begin
      stars_d = 4'(NUM_STARS);
    end else begin
      stars_d = star_sum_s[3:0];
    end
    // count never decreases, so the first arrival at NUM_STARS happens only once
    all_coll_d = (stars_d == 4'(NUM_STARS)) && (stars_q != 4'(NUM_STARS));
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      touch_d_q    <= {NUM_STARS{1'b0}};
      stars_q      <= 4'd0;
      score_q      <= 14'd0;
      power_left_q <= 10'd0;
      blink_q      <= 1'b0;
      blink_cnt_q  <= {BW{1'b0}};
      all_coll_q   <= 1'b0;
      powered_q    <= 1'b0;
`ifdef STAR_COMBO_EN
      combo_q      <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      touch_d_q    <= touch_d_d;
      stars_q      <= stars_d;
      score_q      <= score_d;
      power_left_q <= power_left_d;
      blink_q      <= blink_d;
      blink_cnt_q  <= blink_cnt_d;
      all_coll_q   <= all_coll_d;
      powered_q    <= powered_d;
`ifdef STAR_COMBO_EN
      combo_q      <= combo_d;
`endif
    end
  end

  assign stars_collected = stars_q;
  assign score           = score_q;
  assign powered         = powered_q;
  assign blink           = blink_q;
  assign all_collected   = all_coll_q;
  assign power_left      = power_left_q;

endmodule

// File: tb/tb_star_collect_ctrl.sv
// tb_star_collect_ctrl: table-driven check of star_collect_ctrl with a scoreboard queue.
// Three instances: defaults, SCORE_MAX=250, NUM_STARS=4. Honours STAR_COMBO_EN.
`timescale 1ns/1ps
module tb_star_collect_ctrl;

`ifdef STAR_COMBO_EN
  localparam int S3 = 500;
  localparam int SAT2 = 250;
  localparam int F2 = 300;
  localparam int F3 = 700;
`else
  localparam int S3 = 300;
  localparam int SAT2 = 200;
  localparam int F2 = 200;
  localparam int F3 = 300;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [2:0] t_main;
  logic [2:0] t_sat;
  logic [3:0] t_four;

  logic [3:0]  stars_o [3];
  logic [13:0] score_o [3];
  logic        powered_o [3];
  logic        blink_o [3];
  logic        allc_o [3];
  logic [9:0]  pl_o [3];

  typedef struct {
    int         id;
    int         sel;
    logic [3:0] touch;
    logic       tick;
    int         pre;
    logic [3:0] stars;
    logic [13:0] score;
    logic       powered;
    logic       blink;
    logic       allc;
    logic [9:0] pl;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  star_collect_ctrl dut_main (
    .sys_clk(clk), .RST_N(rst_n), .touch_star(t_main), .frame_tick(frame_tick),
    .stars_collected(stars_o[0]), .score(score_o[0]), .powered(powered_o[0]),
    .blink(blink_o[0]), .all_collected(allc_o[0]), .power_left(pl_o[0])
  );

  star_collect_ctrl #(.SCORE_MAX(250)) dut_sat (
    .sys_clk(clk), .RST_N(rst_n), .touch_star(t_sat), .frame_tick(frame_tick),
    .stars_collected(stars_o[1]), .score(score_o[1]), .powered(powered_o[1]),
    .blink(blink_o[1]), .all_collected(allc_o[1]), .power_left(pl_o[1])
  );

  star_collect_ctrl #(.NUM_STARS(4)) dut_four (
    .sys_clk(clk), .RST_N(rst_n), .touch_star(t_four), .frame_tick(frame_tick),
    .stars_collected(stars_o[2]), .score(score_o[2]), .powered(powered_o[2]),
    .blink(blink_o[2]), .all_collected(allc_o[2]), .power_left(pl_o[2])
  );

  function automatic void add(input int sel, input int touch, input int tick, input int pre,
                              input int stars, input int score, input int pw, input int bl,
                              input int ac, input int pl);
    vec_t v;
    v.id = tbl.size();
    v.sel = sel;
    v.touch = 4'(touch);
    v.tick = 1'(tick);
    v.pre = pre;
    v.stars = 4'(stars);
    v.score = 14'(score);
    v.powered = 1'(pw);
    v.blink = 1'(bl);
    v.allc = 1'(ac);
    v.pl = 10'(pl);
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic compare(input vec_t e);
    int k;
    k = (e.sel > 1) ? 2 : e.sel;
    check($sformatf("row%0d stars", e.id), 32'(stars_o[k]), 32'(e.stars));
    check($sformatf("row%0d score", e.id), 32'(score_o[k]), 32'(e.score));
    check($sformatf("row%0d powered", e.id), 32'(powered_o[k]), 32'(e.powered));
    check($sformatf("row%0d blink", e.id), 32'(blink_o[k]), 32'(e.blink));
    check($sformatf("row%0d all_collected", e.id), 32'(allc_o[k]), 32'(e.allc));
    check($sformatf("row%0d power_left", e.id), 32'(pl_o[k]), 32'(e.pl));
  endtask

  task automatic step(input vec_t v, input bit chk);
    vec_t e;
    @(negedge clk);
    frame_tick = v.tick;
    case (v.sel)
      0: t_main = v.touch[2:0];
      1: t_sat = v.touch[2:0];
      default: t_four = v.touch;
    endcase
    if (chk) exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (chk) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: queue empty at row %0d, expected one entry", v.id);
      end else begin
        e = exp_q.pop_front();
        compare(e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    t_main = 3'd0;
    t_sat = 3'd0;
    t_four = 4'd0;

    //  sel touch tick pre  stars score pw bl ac pl
    add(0, 4'b0000, 0, 0,   0, 0,    0, 0, 0, 0);
    add(0, 4'b0000, 1, 0,   0, 0,    0, 0, 0, 0);
    add(0, 4'b0001, 0, 0,   1, 100,  1, 0, 0, 600);
    add(0, 4'b0001, 0, 0,   1, 100,  1, 0, 0, 600);
    add(0, 4'b0001, 1, 0,   1, 100,  1, 0, 0, 599);
    add(0, 4'b0001, 0, 0,   1, 100,  1, 0, 0, 599);
    add(0, 4'b0001, 1, 477, 1, 100,  1, 0, 0, 121);
    add(0, 4'b0001, 1, 0,   1, 100,  1, 1, 0, 120);
    add(0, 4'b0001, 1, 6,   1, 100,  1, 1, 0, 113);
    add(0, 4'b0001, 1, 0,   1, 100,  1, 0, 0, 112);
    add(0, 4'b0001, 1, 61,  1, 100,  1, 1, 0, 50);
    add(0, 4'b0111, 1, 0,   3, S3,   1, 0, 1, 600);
    add(0, 4'b0111, 0, 0,   3, S3,   1, 0, 0, 600);
    add(0, 4'b0111, 1, 0,   3, S3,   1, 0, 0, 599);
    add(0, 4'b0111, 1, 597, 3, S3,   1, 1, 0, 1);
    add(0, 4'b0111, 1, 0,   3, S3,   0, 0, 0, 0);
    add(0, 4'b0111, 1, 0,   3, S3,   0, 0, 0, 0);
    add(1, 4'b0001, 0, 0,   1, 100,  1, 0, 0, 600);
    add(1, 4'b0011, 0, 0,   2, SAT2, 1, 0, 0, 600);
    add(1, 4'b0111, 0, 0,   3, 250,  1, 0, 1, 600);
    add(1, 4'b0111, 0, 0,   3, 250,  1, 0, 0, 600);
    add(2, 4'b0001, 0, 0,   1, 100,  1, 0, 0, 600);
    add(2, 4'b0011, 0, 0,   2, F2,   1, 0, 0, 600);
    add(2, 4'b0111, 0, 0,   3, F3,   1, 0, 0, 600);
    add(2, 4'b0111, 1, 599, 3, F3,   0, 0, 0, 0);
    add(2, 4'b1111, 0, 0,   4, F3 + 100, 1, 0, 1, 600);
    add(2, 4'b1111, 0, 0,   4, F3 + 100, 1, 0, 0, 600);

    repeat (3) @(posedge clk);
    #1;
    check("in_reset powered", 32'(powered_o[0]), 32'd0);
    check("in_reset power_left", 32'(pl_o[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset%0d stars", k), 32'(stars_o[k]), 32'd0);
      check($sformatf("reset%0d score", k), 32'(score_o[k]), 32'd0);
      check($sformatf("reset%0d powered", k), 32'(powered_o[k]), 32'd0);
      check($sformatf("reset%0d blink", k), 32'(blink_o[k]), 32'd0);
      check($sformatf("reset%0d all_collected", k), 32'(allc_o[k]), 32'd0);
      check($sformatf("reset%0d power_left", k), 32'(pl_o[k]), 32'd0);
    end

    foreach (tbl[i]) begin
      repeat (tbl[i].pre) step(tbl[i], 1'b0);
      step(tbl[i], 1'b1);
    end

    // asynchronous reset while dut_four is powered: clears without a clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst powered", 32'(powered_o[2]), 32'd0);
    check("async_rst power_left", 32'(pl_o[2]), 32'd0);
    check("async_rst stars", 32'(stars_o[2]), 32'd0);
    check("async_rst score", 32'(score_o[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule

// File: doc/star_collect_ctrl.md
Name: star_collect_ctrl

Overview:
- Consumes the sticky per-star touch flags from the star collectible instances (star1..starN).
- Counts collected stars, accumulates score, and runs the star-power (invincibility) timer with its end-of-power warning blink.
- Outputs feed the HUD renderer and the character sprite blink and invulnerability logic.

Parameters:
NUM_STARS, 3, number of star instances; width of touch_star bus (1..8)
STAR_POINTS, 100, score added per newly collected star
SCORE_MAX, 9999, score saturation value
POWER_FRAMES, 600, frames of star power granted per star
WARN_FRAMES, 120, remaining-frame threshold at which the warning blink starts
BLINK_DIV, 8, frames per blink half-period during warning

Ports:
sys_clk  in  1  system clock
RST_N  in  1  asynchronous active-low reset
touch_star  in  NUM_STARS  sticky touch flags, one per star; bit i = touch_star(i+1)
frame_tick  in  1  one-cycle pulse per video frame
stars_collected  out  4  number of stars collected
score  out  14  binary score, saturating at SCORE_MAX
powered  out  1  star power active (states POWER or WARN)
blink  out  1  sprite blink enable; toggles in WARN, 0 otherwise
all_collected  out  1  one-cycle pulse when the last star is collected
power_left  out  10  remaining power frames

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous, active-low, on RST_N. On reset, every output and internal register is 0: the touch_d register, counters, state = IDLE, blink = 0 and the combo level.
- Edge detect:
  - new_mask = touch_star & ~touch_d; touch_d is registered every cycle.
  - Touch inputs are sticky levels, so each star contributes at most one rising edge.
  - A bit that falls and then rises again is counted again. Upstream never does this; verification must not rely on it either way.
- Count:
  - new_cnt = popcount(new_mask). Simultaneous edges in one cycle are all counted.
  - stars_collected += new_cnt, saturating at NUM_STARS.
  - Outputs are registered, so latency is 1 cycle from the touch rising edge to the updated stars_collected.
- Score:
  - score += new_cnt * points. The add is computed in 15 bits and clamped to SCORE_MAX.
  - points = STAR_POINTS unless the optional feature is enabled.
- all_collected: asserts for exactly one cycle, on the cycle stars_collected first becomes NUM_STARS. It never reasserts until reset.
- Power FSM:
  - States: IDLE, POWER, WARN.
  - Any cycle with new_cnt > 0: power_left <= POWER_FRAMES, state <= POWER, blink <= 0. This applies from any state. A reload wins over a simultaneous frame_tick.
  - POWER, on frame_tick: power_left decrements. When the decremented value is <= WARN_FRAMES, go to WARN, clear the blink frame counter and set blink = 1.
  - WARN, on frame_tick:
    - power_left decrements and the blink counter increments.
    - When the blink counter reaches BLINK_DIV, it wraps to 0 and blink toggles.
    - When power_left goes from 1 to 0, state <= IDLE and blink <= 0 in the same cycle.
  - IDLE: power_left holds 0 and frame_tick is ignored.
  - powered = (state != IDLE); it is registered.
  - If POWER_FRAMES <= WARN_FRAMES, the FSM enters WARN on the first frame_tick.
- Reset mid-power: the FSM returns to IDLE immediately and asynchronously. All counts are lost.

Optional Feature:
- Macro: STAR_COMBO_EN.
- When defined:
  - A 2-bit combo level is kept.
  - Collecting a star while powered = 1 increments combo, saturating at 3.
  - Collecting a star while IDLE sets combo to 0.
  - points = STAR_POINTS << combo, using the combo value after the update for that cycle.
  - For simultaneous edges, all stars in that cycle use the same multiplier.
  - combo clears to 0 when the FSM enters IDLE.
- When undefined: no combo register exists and points = STAR_POINTS always. The port list is identical in both builds.

Test Plan:
- Reset check: hold RST_N = 0, then release. Required: all outputs 0 and state IDLE.
- Single star: raise touch_star = 3'b001. Next cycle required: stars_collected = 1, score = 100, powered = 1, power_left = 600. Holding the bit high adds nothing further.
- Power countdown: after one star, issue 480 frame_ticks. Required: power_left = 120, blink = 1. After 8 more ticks blink = 0. After the full 600 ticks: powered = 0, blink = 0, power_left = 0.
- Simultaneous and reload: at power_left = 50 in WARN, raise touch_star bits 1 and 2 in the same cycle as a frame_tick. Required: stars_collected = 3, score = 300, power_left = 600, state POWER, blink = 0, and one all_collected pulse.
- Saturation: with SCORE_MAX = 250, collect 3 stars. Required: score = 250.
- Combo build (STAR_COMBO_EN defined): collect stars one at a time, each within the power window. Required scores: 100, 300, 700. Let power expire, then collect one more star with NUM_STARS = 4. Required: +100 and combo = 0.
